daq_clkdiv_init_seq: RTL and testbench

DAQ_CLKDIV_INIT_SEQ -- requirements
Module: daq_clkdiv_init_seq

---
 rtl/daq_clkdiv_init_seq.sv | 187 ++++++++++++++++++
 tb/tb_daq_clkdiv_init_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/daq_clkdiv_init_seq.sv
// Clock-divider initialisation sequencer.
// Holds the divider in reset for at least MIN_RST_CYC cycles, then waits for a
// synchronized LOCKED to stay high for LOCK_STABLE consecutive cycles. A lock
// attempt that times out is retried up to MAX_RETRY times before reporting
// LOCK_ERR. A lock loss while DONE re-enters reset and sets a sticky LOCK_LOST.
// CDV_INIT high forces the reset hold from any state.
module daq_clkdiv_init_seq #(
   parameter int MIN_RST_CYC  = 8,
   parameter int LOCK_STABLE  = 16,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int MAX_RETRY    = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CDV_INIT,
   input  logic       LOCKED,
   output logic       DIV_RST,
   output logic       CDV_DONE,
   output logic       LOCK_ERR,
   output logic       LOCK_LOST,
   output logic [1:0] RETRY_CNT,
   output logic [1:0] DIVI_STATE
);

   localparam int HOLD_W = $clog2(MIN_RST_CYC + 1);
   localparam int STAB_W = $clog2(LOCK_STABLE + 1);
   localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

   // Terminal counts: a counter holding the value *_LAST means this is the
   // last cycle of the corresponding window.
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_RST_CYC - 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

   typedef enum logic [1:0] {
      ST_RST_HOLD  = 2'b00,
      ST_WAIT_LOCK = 2'b01,
      ST_DONE      = 2'b10,
      ST_FAIL      = 2'b11
   } state_t;

   state_t              r_state;
   state_t              w_nxt;
   logic                r_lock_meta;
   logic                r_lock_s;
   logic                r_init_d;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [STAB_W-1:0]   r_stab_cnt;
   logic [TMO_W-1:0]    r_tmo_cnt;
   logic [1:0]          r_retry;
   logic                r_div_rst;
   logic                r_cdv_done;
   logic                r_lock_err;
   logic                r_lock_lost;

   logic                w_init_rise;
   logic                w_lock_ok;
   logic                w_timeout;
   logic                w_retry_inc;
   logic                w_lost;

   assign w_init_rise = CDV_INIT & ~r_init_d;
   assign w_lock_ok   = (r_state == ST_WAIT_LOCK) && r_lock_s && (r_stab_cnt == STAB_LAST);
   assign w_timeout   = (r_state == ST_WAIT_LOCK) && (r_tmo_cnt == TMO_LAST);

   // Two-flop synchronizer for the asynchronous lock input, plus CDV_INIT history.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
         r_init_d    <= 1'b0;
      end else begin
         r_lock_meta <= LOCKED;
         r_lock_s    <= r_lock_meta;
         r_init_d    <= CDV_INIT;
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_RST_HOLD;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Next-state logic; CDV_INIT overrides every other transition, and lock
   // completion beats a coincident timeout.
   always_comb begin
      w_nxt       = r_state;
      w_retry_inc = 1'b0;
      w_lost      = 1'b0;
      if (CDV_INIT) begin
         w_nxt = ST_RST_HOLD;
      end else begin
         case (r_state)
            ST_RST_HOLD: begin
               if (r_hold_cnt >= HOLD_LAST) w_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (w_lock_ok) begin
                  w_nxt = ST_DONE;
               end else if (w_timeout) begin
                  if (r_retry < RETRY_MAX) begin
                     w_nxt       = ST_RST_HOLD;
                     w_retry_inc = 1'b1;
                  end else begin
                     w_nxt = ST_FAIL;
                  end
               end
            end
            ST_DONE: begin
               if (!r_lock_s) begin
                  w_nxt  = ST_RST_HOLD;
                  w_lost = 1'b1;
               end
            end
            default: w_nxt = r_state;
         endcase
      end
   end

   // Phase counters: cleared on entry to their state, saturating while in it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_hold_cnt <= '0;
         r_stab_cnt <= '0;
         r_tmo_cnt  <= '0;
      end else begin
         if (r_state != ST_RST_HOLD || w_nxt != ST_RST_HOLD)
            r_hold_cnt <= '0;
         else if (r_hold_cnt < HOLD_LAST)
            r_hold_cnt <= r_hold_cnt + 1'b1;

         if (r_state != ST_WAIT_LOCK || w_nxt != ST_WAIT_LOCK || !r_lock_s)
            r_stab_cnt <= '0;
         else if (r_stab_cnt < STAB_LAST)
            r_stab_cnt <= r_stab_cnt + 1'b1;

         if (r_state != ST_WAIT_LOCK || w_nxt != ST_WAIT_LOCK)
            r_tmo_cnt <= '0;
         else if (r_tmo_cnt < TMO_LAST)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // Retry count and sticky lock-lost flag; a new CDV_INIT request starts a fresh sequence.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_retry     <= '0;
         r_lock_lost <= 1'b0;
      end else begin
         if (w_init_rise)
            r_retry <= '0;
         else if (w_retry_inc)
            r_retry <= r_retry + 1'b1;

         if (w_init_rise)
            r_lock_lost <= 1'b0;
         else if (w_lost)
            r_lock_lost <= 1'b1;
      end
   end

   // Status outputs decoded from the next state so they move with the state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_div_rst  <= 1'b1;
         r_cdv_done <= 1'b0;
         r_lock_err <= 1'b0;
      end else begin
         r_div_rst  <= (w_nxt == ST_RST_HOLD);
         r_cdv_done <= (w_nxt == ST_DONE);
         r_lock_err <= (w_nxt == ST_FAIL);
      end
   end

   assign DIV_RST    = r_div_rst;
   assign CDV_DONE   = r_cdv_done;
   assign LOCK_ERR   = r_lock_err;
   assign LOCK_LOST  = r_lock_lost;
   assign RETRY_CNT  = r_retry;
   assign DIVI_STATE = r_state;

endmodule

// File: tb/tb_daq_clkdiv_init_seq.sv
// Testbench for daq_clkdiv_init_seq: directed vector table plus hand-written
// sequences for timeout/retry/FAIL, asynchronous reset and lock/timeout tie.
module tb_daq_clkdiv_init_seq;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CDV_INIT;
   logic       LOCKED;
   logic       DIV_RST;
   logic       CDV_DONE;
   logic       LOCK_ERR;
   logic       LOCK_LOST;
   logic [1:0] RETRY_CNT;
   logic [1:0] DIVI_STATE;

   int n_cmp = 0;
   int n_bad = 0;

   daq_clkdiv_init_seq #(
      .MIN_RST_CYC (8),
      .LOCK_STABLE (16),
      .LOCK_TIMEOUT(1024),
      .MAX_RETRY   (3)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CDV_INIT  (CDV_INIT),
      .LOCKED    (LOCKED),
      .DIV_RST   (DIV_RST),
      .CDV_DONE  (CDV_DONE),
      .LOCK_ERR  (LOCK_ERR),
      .LOCK_LOST (LOCK_LOST),
      .RETRY_CNT (RETRY_CNT),
      .DIVI_STATE(DIVI_STATE)
   );

   always #5 CLK = ~CLK;

   // Run-length guard.
   initial begin
      #(90000 * 10);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk_all(input string tag, input int dv, input int dn, input int er,
                          input int ls, input int rc, input int st);
      chk({tag, ".DIV_RST"},    int'(DIV_RST),    dv);
      chk({tag, ".CDV_DONE"},   int'(CDV_DONE),   dn);
      chk({tag, ".LOCK_ERR"},   int'(LOCK_ERR),   er);
      chk({tag, ".LOCK_LOST"},  int'(LOCK_LOST),  ls);
      chk({tag, ".RETRY_CNT"},  int'(RETRY_CNT),  rc);
      chk({tag, ".DIVI_STATE"}, int'(DIVI_STATE), st);
   endtask

   typedef struct {
      logic init;
      logic lock;
      int   n;
      int   div;
      int   done;
      int   err;
      int   lost;
      int   retry;
      int   st;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int k;

      // Edge numbering R1, R2, ... counts rising edges after reset release.
      // Lock latency: 2 synchronizer edges, then LOCK_STABLE samples.
      tbl[0]  = '{1'b0, 1'b0,  7, 1, 0, 0, 0, 0, 0};  // R7 : still in hold
      tbl[1]  = '{1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 1};  // R8 : hold of 8 ends
      tbl[2]  = '{1'b0, 1'b1, 17, 0, 0, 0, 0, 0, 1};  // R25: 17 edges after fall, not yet
      tbl[3]  = '{1'b0, 1'b1,  1, 0, 1, 0, 0, 0, 2};  // R26: 18 edges after fall -> DONE
      tbl[4]  = '{1'b0, 1'b0,  2, 0, 1, 0, 0, 0, 2};  // R28: drop still in synchronizer
      tbl[5]  = '{1'b0, 1'b0,  1, 1, 0, 0, 1, 0, 0};  // R29: lock lost -> hold
      tbl[6]  = '{1'b0, 1'b0, 10, 0, 0, 0, 1, 0, 1};  // R39: LOCK_LOST sticky
      tbl[7]  = '{1'b1, 1'b0,  1, 1, 0, 0, 0, 0, 0};  // R40: init rise clears lost
      tbl[8]  = '{1'b1, 1'b0,  1, 1, 0, 0, 0, 0, 0};  // R41: 2-cycle init pulse
      tbl[9]  = '{1'b0, 1'b0,  6, 1, 0, 0, 0, 0, 0};  // R47: 8th DIV_RST cycle
      tbl[10] = '{1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 1};  // R48: released after exactly 8
      tbl[11] = '{1'b1, 1'b0, 20, 1, 0, 0, 0, 0, 0};  // R68: 20-cycle init
      tbl[12] = '{1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 1};  // R69: released after 20
      tbl[13] = '{1'b1 ^ 1'b1, 1'b1, 15, 0, 0, 0, 0, 0, 1};  // R84: 15 high samples queued
      tbl[14] = '{1'b0, 1'b0,  1, 0, 0, 0, 0, 0, 1};  // R85: one low sample
      tbl[15] = '{1'b0, 1'b1, 17, 0, 0, 0, 0, 0, 1};  // R102: count restarted
      tbl[16] = '{1'b0, 1'b1,  1, 0, 1, 0, 0, 0, 2};  // R103: 16 consecutive -> DONE
      tbl[17] = '{1'b1, 1'b1,  1, 1, 0, 0, 0, 0, 0};  // R104: init drops DONE at once
      tbl[18] = '{1'b0, 1'b1, 23, 0, 0, 0, 0, 0, 1};  // R127: lock already stable
      tbl[19] = '{1'b0, 1'b1,  1, 0, 1, 0, 0, 0, 2};  // R128: DONE 16 edges after fall

      RST      = 1'b1;
      CDV_INIT = 1'b0;
      LOCKED   = 1'b0;
      tick(3);
      chk_all("reset", 1, 0, 0, 0, 0, 0);
      RST = 1'b0;

      for (int i = 0; i < 20; i++) begin
         CDV_INIT = tbl[i].init;
         LOCKED   = tbl[i].lock;
         tick(tbl[i].n);
         chk_all($sformatf("row%0d", i), tbl[i].div, tbl[i].done, tbl[i].err,
                 tbl[i].lost, tbl[i].retry, tbl[i].st);
      end

      // Lock never arrives: 8-cycle holds, 1024-cycle waits, retries 1..3, then FAIL.
      CDV_INIT = 1'b1;
      LOCKED   = 1'b0;
      tick(1);
      CDV_INIT = 1'b0;
      for (int att = 0; att < 4; att++) begin
         k = 0;
         while (DIV_RST && k < 50) begin
            tick(1);
            k++;
         end
         chk($sformatf("att%0d.hold_len", att), k, 8);
         chk($sformatf("att%0d.wait_state", att), int'(DIVI_STATE), 1);
         k = 0;
         while (DIVI_STATE == 2'b01 && k < 1100) begin
            tick(1);
            k++;
         end
         chk($sformatf("att%0d.wait_len", att), k, 1024);
         if (att < 3)
            chk_all($sformatf("att%0d.retry", att), 1, 0, 0, 0, att + 1, 0);
         else
            chk_all("fail", 0, 0, 1, 0, 3, 3);
      end
      tick(5);
      chk_all("fail_hold", 0, 0, 1, 0, 3, 3);
      CDV_INIT = 1'b1;
      tick(1);
      CDV_INIT = 1'b0;
      chk_all("fail_clear", 1, 0, 0, 0, 0, 0);

      // Asynchronous reset in WAIT_LOCK with two retries taken.
      k = 0;
      while (!(RETRY_CNT == 2'd2 && DIVI_STATE == 2'b01) && k < 4000) begin
         tick(1);
         k++;
      end
      chk("reach_retry2_wait", int'(RETRY_CNT == 2'd2 && DIVI_STATE == 2'b01), 1);
      tick(5);
      #2;
      RST = 1'b1;
      #1;
      chk_all("async_rst", 1, 0, 0, 0, 0, 0);
      tick(1);
      RST = 1'b0;
      tick(7);
      chk_all("rst_rehold", 1, 0, 0, 0, 0, 0);
      tick(1);
      chk_all("rst_release", 0, 0, 0, 0, 0, 1);

      // Lock completion on the same cycle as the timeout: DONE must win.
      // Entry edge X; LOCKED first sampled high at X+1007 puts the 16th
      // stable sample on WAIT cycle 1023, the timeout cycle.
      tick(1006);
      LOCKED = 1'b1;
      tick(17);
      chk_all("tie_before", 0, 0, 0, 0, 0, 1);
      tick(1);
      chk_all("tie_done", 0, 1, 0, 0, 0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
